// File: rtl/tdc_pkg.sv
// Shared definitions for the dtc/tdc time-domain pair; both sides must agree on operand width.
package tdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_GAP   = 1;

    function automatic int cnt_width(input int width);
        return (width > 4) ? width : 4;
    endfunction

endpackage

// File: rtl/dtc.sv
// Digital-to-time converter: one operand -> one out pulse of that many cycles, then GAP low cycles.
// Latency: out rises on the accept edge, done strobes D+GAP edges later; in_ready low while busy, nothing queued.
module dtc
    import tdc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          accept;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // cnt holds the number of cycles remaining after the current one in PULSE/GAP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_data != '0) begin
                        state_d = ST_PULSE;
                        cnt_d   = CW'(in_data) - CW'(1);
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LD;
                    end
                end
            end
            ST_PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        out_d  = (state_d == ST_PULSE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_GAP) && (state_d == ST_IDLE);
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_dtc.sv
// Directed bench for dtc: default instance (WIDTH=4, GAP=1) and a WIDTH=6, GAP=3 instance.
module tb_dtc;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       a_valid = 1'b0;
    logic [3:0] a_data  = '0;
    logic       a_ready, a_out, a_busy, a_done;

    logic       b_valid = 1'b0;
    logic [5:0] b_data  = '0;
    logic       b_ready, b_out, b_busy, b_done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic sel = 1'b0;
    logic m_ready, m_out, m_busy, m_done;

    assign m_ready = sel ? b_ready : a_ready;
    assign m_out   = sel ? b_out   : a_out;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;

    dtc u_dtc_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .in_data  (a_data),
        .out      (a_out),
        .busy     (a_busy),
        .done     (a_done)
    );

    dtc #(.WIDTH(6), .GAP(3)) u_dtc_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .in_data  (b_data),
        .out      (b_out),
        .busy     (b_busy),
        .done     (b_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec = n_vec + 1;
        if (obs != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic vld, input int d);
        if (sel) begin
            b_valid = vld;
            b_data  = d[5:0];
        end else begin
            a_valid = vld;
            a_data  = d[3:0];
        end
    endtask

    // After the last pulse cycle has been sampled: count GAP low cycles, then check the done strobe
    task automatic finish_op(input string tag, input int gap);
        int lo;
        lo = 0;
        while (m_busy && !m_out && !m_done && lo < 40) begin
            lo = lo + 1;
            tick();
        end
        chk({tag, " gap"}, lo, gap);
        chk({tag, " done"}, int'(m_done), 1);
        chk({tag, " busy_end"}, int'(m_busy), 0);
        chk({tag, " ready_end"}, int'(m_ready), 1);
        tick();
        chk({tag, " done_1cyc"}, int'(m_done), 0);
    endtask

    task automatic measure_high(input string tag, input int d);
        int hi;
        hi = 0;
        while (m_out && hi < 200) begin
            hi = hi + 1;
            tick();
        end
        chk({tag, " width"}, hi, d);
    endtask

    task automatic run_op(input string tag, input int d, input int gap);
        int w;
        w = 0;
        while (!m_ready && w < 100) begin
            w = w + 1;
            tick();
        end
        if (w >= 100) chk({tag, " ready_timeout"}, 1, 0);
        set_in(1'b1, d);
        tick();
        set_in(1'b0, 0);
        chk({tag, " busy_start"}, int'(m_busy), 1);
        chk({tag, " out_start"}, int'(m_out), (d != 0) ? 1 : 0);
        measure_high(tag, d);
        finish_op(tag, gap);
    endtask

    initial begin
        int r1, r2;

        // Reset behaviour
        rst = 1'b0;
        tick();
        tick();
        chk("rst out", int'(a_out), 0);
        chk("rst busy", int'(a_busy), 0);
        rst = 1'b1;
        tick();
        chk("rel out", int'(a_out), 0);
        chk("rel busy", int'(a_busy), 0);
        chk("rel done", int'(a_done), 0);
        chk("rel ready", int'(a_ready), 1);
        chk("rel b ready", int'(b_ready), 1);

        // Single operand and boundaries
        run_op("op5", 5, 1);
        run_op("op0", 0, 1);
        run_op("op15", 15, 1);
        run_op("op1", 1, 1);

        // Back-to-back with in_valid held high; in_data changes while busy are ignored
        a_valid = 1'b1;
        a_data  = 4'd3;
        tick();
        r1 = cyc;
        chk("b2b out1", int'(a_out), 1);
        a_data = 4'd9;
        measure_high("b2b p1", 3);
        chk("b2b gap busy", int'(a_busy), 1);
        tick();
        chk("b2b done", int'(a_done), 1);
        chk("b2b ready", int'(a_ready), 1);
        a_data = 4'd2;
        tick();
        r2 = cyc;
        a_valid = 1'b0;
        chk("b2b out2", int'(a_out), 1);
        chk("b2b done_gone", int'(a_done), 0);
        chk("b2b rise_sep", r2 - r1, 5);
        measure_high("b2b p2", 2);
        finish_op("b2b p2", 1);

        // Asynchronous reset in the second cycle of a 7-cycle pulse
        a_valid = 1'b1;
        a_data  = 4'd7;
        tick();
        a_valid = 1'b0;
        tick();
        chk("mid out_before", int'(a_out), 1);
        #3;
        rst = 1'b0;
        #1;
        chk("mid out", int'(a_out), 0);
        chk("mid busy", int'(a_busy), 0);
        chk("mid done", int'(a_done), 0);
        chk("mid ready", int'(a_ready), 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid idle out", int'(a_out), 0);
        run_op("post_rst4", 4, 1);

        // Wider instance: WIDTH=6, GAP=3
        sel = 1'b1;
        #1;
        run_op("w6 op40", 40, 3);
        run_op("w6 op63", 63, 3);
        run_op("w6 op0", 0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
